// File: rtl/image_sobel_gradient_pkg.sv
// Shared definitions for the Sobel/Canny edge path: the direction encoding and
// the fixed-point tangent thresholds used to bin the gradient angle.
package image_sobel_gradient_pkg;

   // Quantized gradient direction
   typedef enum logic [1:0] {
      DIR_0   = 2'd0,
      DIR_45  = 2'd1,
      DIR_90  = 2'd2,
      DIR_135 = 2'd3
   } grad_dir_e;

   // tan(22.5 deg) and tan(67.5 deg), scaled by 256
   localparam int unsigned TAN22_X256 = 106;
   localparam int unsigned TAN67_X256 = 618;

   // Input clken to output clken: window, Gx/Gy, abs/sum, saturate/quantize
   localparam int unsigned PIPE_DEPTH = 4;

endpackage

// File: rtl/image_sobel_gradient_line_buffer.sv
// Two-row pixel store. A write at a column pushes the row_m1 entry down into
// row_m2 and stores the new pixel, so reads return the two previous lines.
module sobel_line_buffer #(
   parameter int IMG_WIDTH  = 1920,
   parameter int DATA_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         wr_en,
   input  logic [$clog2(IMG_WIDTH)-1:0] addr,
   input  logic [DATA_WIDTH-1:0]        din,
   output logic [DATA_WIDTH-1:0]        row_m1,
   output logic [DATA_WIDTH-1:0]        row_m2
);
   logic [DATA_WIDTH-1:0] mem_m1 [IMG_WIDTH];
   logic [DATA_WIDTH-1:0] mem_m2 [IMG_WIDTH];

   // Column write: age the previous line into the older slot, store the new pixel
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_m2[addr] <= mem_m1[addr];
         mem_m1[addr] <= din;
      end
   end

   assign row_m1 = mem_m1[addr];
   assign row_m2 = mem_m2[addr];

endmodule

// File: rtl/image_sobel_gradient.sv
// Sobel gradient stage: 3x3 window over two line buffers feeding a 4-deep
// pipeline that produces min(max, (|Gx|+|Gy|)/2) and a 4-way direction bin.
// Output refers to the window centre (row-1, col-1) of the pixel just taken in.
module image_sobel_gradient
   import image_sobel_gradient_pkg::*;
#(
   parameter int IMG_WIDTH  = 1920,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  per_frame_vsync,
   input  logic                  per_frame_href,
   input  logic                  per_frame_clken,
   input  logic [DATA_WIDTH-1:0] per_img_gray,
   output logic                  post_frame_vsync,
   output logic                  post_frame_href,
   output logic                  post_frame_clken,
   output logic [DATA_WIDTH-1:0] post_grad_mag,
   output logic [1:0]            post_grad_dir
);
   localparam int CW = $clog2(IMG_WIDTH + 1);
   localparam int IW = $clog2(IMG_WIDTH);
   localparam int GW = DATA_WIDTH + 3;
   localparam int SW = GW + 1;
   localparam int PW = GW + 10;
   localparam logic [CW-1:0]         COL_LIM = CW'(IMG_WIDTH);
   localparam logic [DATA_WIDTH-1:0] MAG_MAX = '1;

   logic                  vsync_q, href_q, frame_seen;
   logic                  vsync_rise, href_rise, href_fall;
   logic [CW-1:0]         col, col_eff;
   logic [1:0]            row, row_eff;
   logic                  col_ok, border_in, buf_wr;
   logic [IW-1:0]         buf_addr;
   logic [DATA_WIDTH-1:0] row_m1, row_m2;
   logic [PIPE_DEPTH-1:0] vsync_d, href_d, clken_d;

   logic [DATA_WIDTH-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
   logic                  border1, border2, border3;
   logic [GW-1:0]         gx_pos, gx_neg, gy_pos, gy_neg;
   logic signed [GW-1:0]  gx, gy;
   logic [GW-1:0]         ax_c, ay_c, ax, ay, half;
   logic [SW-1:0]         sum_c;
   logic                  sx, sy;
   logic [PW-1:0]         ay_x256, ax_x106, ax_x618;
   grad_dir_e             dir_c;
   logic [DATA_WIDTH-1:0] mag_c, grad_mag_q;
   logic [1:0]            grad_dir_q;

   // A vsync or href rising edge clears the position for the pixel arriving with it
   assign vsync_rise = per_frame_vsync & ~vsync_q;
   assign href_rise  = per_frame_href & ~href_q;
   assign href_fall  = ~per_frame_href & href_q;
   assign col_eff    = (vsync_rise | href_rise) ? '0 : col;
   assign row_eff    = vsync_rise ? 2'd0 : row;
   assign col_ok     = col_eff < COL_LIM;
   assign buf_addr   = col_ok ? col_eff[IW-1:0] : '0;
   assign buf_wr     = per_frame_clken & col_ok;
   // Until a vsync has been seen since reset, row has no meaning
   assign border_in  = ~frame_seen | (row_eff != 2'd2) | (col_eff < CW'(2)) | ~col_ok;

   sobel_line_buffer #(
      .IMG_WIDTH (IMG_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
   ) u_line_buffer (
      .clk   (clk),
      .wr_en (buf_wr),
      .addr  (buf_addr),
      .din   (per_img_gray),
      .row_m1(row_m1),
      .row_m2(row_m2)
   );

   // Position tracking: col saturates at IMG_WIDTH, row saturates at 2
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q    <= 1'b0;
         href_q     <= 1'b0;
         frame_seen <= 1'b0;
         col        <= '0;
         row        <= 2'd0;
      end else begin
         vsync_q <= per_frame_vsync;
         href_q  <= per_frame_href;
         if (vsync_rise)
            frame_seen <= 1'b1;
         if (per_frame_clken && col_ok)
            col <= col_eff + CW'(1);
         else
            col <= col_eff;
         if (vsync_rise)
            row <= 2'd0;
         else if (href_fall && row != 2'd2)
            row <= row + 2'd1;
      end
   end

   // Sync/strobe delay chain, free-running so gaps pass through unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_d <= '0;
         href_d  <= '0;
         clken_d <= '0;
      end else begin
         vsync_d <= {vsync_d[PIPE_DEPTH-2:0], per_frame_vsync};
         href_d  <= {href_d[PIPE_DEPTH-2:0], per_frame_href};
         clken_d <= {clken_d[PIPE_DEPTH-2:0], per_frame_clken};
      end
   end

   // Stage 1: shift the 3x3 window left, newest column on the right
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {p11, p12, p13, p21, p22, p23, p31, p32, p33} <= '0;
         border1 <= 1'b0;
      end else if (per_frame_clken) begin
         p11 <= p12;  p12 <= p13;  p13 <= row_m2;
         p21 <= p22;  p22 <= p23;  p23 <= row_m1;
         p31 <= p32;  p32 <= p33;  p33 <= per_img_gray;
         border1 <= border_in;
      end
   end

   assign gx_pos = GW'(p13) + (GW'(p23) << 1) + GW'(p33);
   assign gx_neg = GW'(p11) + (GW'(p21) << 1) + GW'(p31);
   assign gy_pos = GW'(p31) + (GW'(p32) << 1) + GW'(p33);
   assign gy_neg = GW'(p11) + (GW'(p12) << 1) + GW'(p13);

   // Stage 2: signed Gx/Gy; the wrap-around difference is the exact signed value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gx      <= '0;
         gy      <= '0;
         border2 <= 1'b0;
      end else if (clken_d[0]) begin
         gx      <= gx_pos - gx_neg;
         gy      <= gy_pos - gy_neg;
         border2 <= border1;
      end
   end

   assign ax_c  = gx[GW-1] ? -gx : gx;
   assign ay_c  = gy[GW-1] ? -gy : gy;
   assign sum_c = {1'b0, ax_c} + {1'b0, ay_c};

   // Stage 3: magnitudes, signs and the halved L1 sum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ax      <= '0;
         ay      <= '0;
         sx      <= 1'b0;
         sy      <= 1'b0;
         half    <= '0;
         border3 <= 1'b0;
      end else if (clken_d[1]) begin
         ax      <= ax_c;
         ay      <= ay_c;
         sx      <= gx[GW-1];
         sy      <= gy[GW-1];
         half    <= GW'(sum_c >> 1);
         border3 <= border2;
      end
   end

   assign ay_x256 = PW'(ay) << 8;
   assign ax_x106 = PW'(ax) * PW'(TAN22_X256);
   assign ax_x618 = PW'(ax) * PW'(TAN67_X256);
   assign mag_c   = border3 ? '0 : ((half > GW'(MAG_MAX)) ? MAG_MAX : half[DATA_WIDTH-1:0]);

   // Angle bin by comparing |Gy|/|Gx| against the scaled tangent thresholds
   always_comb begin
      dir_c = DIR_0;
      if (border3 || (ax == '0 && ay == '0))
         dir_c = DIR_0;
      else if (ay_x256 < ax_x106)
         dir_c = DIR_0;
      else if (ay_x256 > ax_x618)
         dir_c = DIR_90;
      else if (sx == sy)
         dir_c = DIR_45;
      else
         dir_c = DIR_135;
   end

   // Stage 4: registered magnitude and direction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grad_mag_q <= '0;
         grad_dir_q <= 2'd0;
      end else if (clken_d[2]) begin
         grad_mag_q <= mag_c;
         grad_dir_q <= dir_c;
      end
   end

   assign post_frame_vsync = vsync_d[PIPE_DEPTH-1];
   assign post_frame_href  = href_d[PIPE_DEPTH-1];
   assign post_frame_clken = clken_d[PIPE_DEPTH-1];
   assign post_grad_mag    = grad_mag_q;
   assign post_grad_dir    = grad_dir_q;

endmodule

// File: tb/tb_image_sobel_gradient.sv
// Bench for image_sobel_gradient: frames are driven from an image array, the
// expected output of every pixel is queued from a plain Sobel model, and a
// negedge process compares sync delays and every valid output against it.
module tb_image_sobel_gradient;
   localparam int W    = 8;
   localparam int HIST = 8192;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       per_frame_vsync, per_frame_href, per_frame_clken;
   logic [7:0] per_img_gray;
   logic       post_frame_vsync, post_frame_href, post_frame_clken;
   logic [7:0] post_grad_mag;
   logic [1:0] post_grad_dir;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int img [4][10];
   int exp_mag_q [$];
   int exp_dir_q [$];
   bit model_frame_ok = 1'b0;
   logic [2:0] in_hist [HIST];
   bit         rst_hist [HIST];

   always #5 clk = ~clk;

   image_sobel_gradient #(.IMG_WIDTH(W), .DATA_WIDTH(8)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .per_frame_vsync (per_frame_vsync),
      .per_frame_href  (per_frame_href),
      .per_frame_clken (per_frame_clken),
      .per_img_gray    (per_img_gray),
      .post_frame_vsync(post_frame_vsync),
      .post_frame_href (post_frame_href),
      .post_frame_clken(post_frame_clken),
      .post_grad_mag   (post_grad_mag),
      .post_grad_dir   (post_grad_dir)
   );

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Plain Sobel on a 3x3 window, row-major, top row oldest
   function automatic void sobel_win(input int w[9], output int mag, output int dir);
      int gx, gy, ax, ay;
      gx = (w[2] + 2*w[5] + w[8]) - (w[0] + 2*w[3] + w[6]);
      gy = (w[6] + 2*w[7] + w[8]) - (w[0] + 2*w[1] + w[2]);
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
      mag = (ax + ay) / 2;
      if (mag > 255) mag = 255;
      if (ax == 0 && ay == 0)      dir = 0;
      else if (256*ay < 106*ax)    dir = 0;
      else if (256*ay > 618*ax)    dir = 2;
      else if ((gx >= 0) == (gy >= 0)) dir = 1;
      else                         dir = 3;
   endfunction

   task automatic pin(input string name, input int w[9], input int em, input int ed);
      int m, d;
      sobel_win(w, m, d);
      check({name, "_mag"}, m, em);
      check({name, "_dir"}, d, ed);
   endtask

   function automatic void fill(input int pat);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 10; c++)
            case (pat)
               0:       img[r][c] = 100;
               1:       img[r][c] = (c >= 4) ? 255 : 0;
               2:       img[r][c] = (r >= 2) ? 40 : 0;
               3:       img[r][c] = 10 * (r + c);
               4:       img[r][c] = (c < 8) ? 10 * (r + 7 - c) : 0;
               default: img[r][c] = int'($urandom_range(0, 255));
            endcase
   endfunction

   task automatic push_expected(input int r, input int c);
      int w[9];
      int m, d;
      if (!model_frame_ok || r < 2 || c < 2 || c >= W) begin
         m = 0;
         d = 0;
      end else begin
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               w[i*3+j] = img[r-2+i][c-2+j];
         sobel_win(w, m, d);
      end
      exp_mag_q.push_back(m);
      exp_dir_q.push_back(d);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      per_frame_clken = 1'b0;
      rst_n = 1'b0;
      model_frame_ok = 1'b0;
      #1;
      check("rst_async_vsync", int'(post_frame_vsync), 0);
      check("rst_async_href", int'(post_frame_href), 0);
      check("rst_async_clken", int'(post_frame_clken), 0);
      check("rst_async_mag", int'(post_grad_mag), 0);
      check("rst_async_dir", int'(post_grad_dir), 0);
      exp_mag_q.delete();
      exp_dir_q.delete();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // One frame of 4 lines of len pixels; rst_at < 0 means no reset pulse
   task automatic run_frame(input int len, input bit gaps, input int rst_at);
      per_frame_vsync = 1'b1;
      model_frame_ok  = 1'b1;
      tick();
      tick();
      per_frame_vsync = 1'b0;
      tick();
      tick();
      for (int r = 0; r < 4; r++) begin
         per_frame_href = 1'b1;
         for (int c = 0; c < len; c++) begin
            if (r*len + c == rst_at) pulse_reset();
            if (gaps && $urandom_range(0, 1) == 1) begin
               per_frame_clken = 1'b0;
               per_img_gray    = 8'd0;
               tick();
            end
            per_frame_clken = 1'b1;
            per_img_gray    = 8'(img[r][c]);
            push_expected(r, c);
            tick();
         end
         per_frame_clken = 1'b0;
         per_img_gray    = 8'd0;
         per_frame_href  = 1'b0;
         repeat (3) tick();
      end
   endtask

   // Record inputs and reset as seen by each rising edge
   always @(posedge clk) begin
      if (cyc < HIST) begin
         in_hist[cyc]  <= {per_frame_vsync, per_frame_href, per_frame_clken};
         rst_hist[cyc] <= rst_n;
      end
      cyc <= cyc + 1;
   end

   // Compare: sync chain every cycle, mag/dir on every valid output
   always @(negedge clk) begin
      logic [2:0] exp_ctl;
      exp_ctl = 3'b000;
      if (rst_n && cyc >= 4 && cyc <= HIST && rst_hist[cyc-4] && rst_hist[cyc-3] &&
          rst_hist[cyc-2] && rst_hist[cyc-1])
         exp_ctl = in_hist[cyc-4];
      check("ctl_delay", int'({post_frame_vsync, post_frame_href, post_frame_clken}), int'(exp_ctl));
      if (!rst_n) begin
         check("rst_mag", int'(post_grad_mag), 0);
         check("rst_dir", int'(post_grad_dir), 0);
      end else if (post_frame_clken) begin
         if (exp_mag_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL out_extra: got an output with no expected pixel (t=%0t)", $time);
         end else begin
            check("mag", int'(post_grad_mag), exp_mag_q.pop_front());
            check("dir", int'(post_grad_dir), exp_dir_q.pop_front());
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int w[9];
      rst_n           = 1'b0;
      per_frame_vsync = 1'b0;
      per_frame_href  = 1'b0;
      per_frame_clken = 1'b0;
      per_img_gray    = 8'd0;

      w = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
      pin("pin_flat", w, 0, 0);
      w = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
      pin("pin_vedge_c3", w, 255, 0);
      w = '{0, 255, 255, 0, 255, 255, 0, 255, 255};
      pin("pin_vedge_c4", w, 255, 0);
      w = '{0, 0, 0, 0, 0, 0, 40, 40, 40};
      pin("pin_hedge", w, 80, 2);
      w = '{0, 10, 20, 10, 20, 30, 20, 30, 40};
      pin("pin_ramp", w, 80, 1);
      w = '{70, 60, 50, 80, 70, 60, 90, 80, 70};
      pin("pin_mirror", w, 80, 3);

      repeat (3) tick();
      check("reset_mag", int'(post_grad_mag), 0);
      check("reset_dir", int'(post_grad_dir), 0);
      check("reset_clken", int'(post_frame_clken), 0);
      rst_n = 1'b1;
      repeat (2) tick();

      fill(0); run_frame(8, 1'b0, -1);
      fill(1); run_frame(8, 1'b0, -1);
      fill(2); run_frame(8, 1'b0, -1);
      fill(3); run_frame(8, 1'b0, -1);
      fill(4); run_frame(8, 1'b0, -1);
      fill(3); run_frame(8, 1'b1, -1);
      fill(5); run_frame(8, 1'b1, -1);
      fill(3); run_frame(10, 1'b0, -1);
      fill(5); run_frame(8, 1'b0, 2*8 + 3);
      fill(3); run_frame(8, 1'b0, -1);
      fill(5); run_frame(8, 1'b0, -1);

      repeat (8) tick();
      check("drain_left", exp_mag_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
